lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/control_types.sv | 44 ++++
 rtl/lsu_ctrl_if.sv | 38 +++
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu_ctrl.sv | 129 ++++++++++++
 tb/tb_lsu_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_types.sv
// control_types -- shared control encodings for the core datapath.
//   mem_op_e    : memory operation direction (READ load, WRITE store)
//   lsu_state_e : load/store unit FSM states
//   lsu_size_e  : funct3 size/sign encodings of LOAD/STORE
//   lsu_legal / lsu_misaligned : request screening used in the IDLE state
package control_types;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_op_e;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_RESP   = 2'd2
   } lsu_state_e;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } lsu_size_e;

   // Unsigned sizes only make sense for loads.
   function automatic logic lsu_legal(input mem_op_e op, input logic [2:0] f3);
      case (f3)
         SZ_B, SZ_H, SZ_W: return 1'b1;
         SZ_BU, SZ_HU:     return (op == READ);
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         SZ_H, SZ_HU: return off[0];
         SZ_W:        return (off != 2'b00);
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- bundles the core-side LOAD/STORE request/response signals
// and the memory-side request/ack bus of the load/store unit.
//   slave  : the LSU (consumes core requests, drives memory requests)
//   master : the environment (core pipeline plus memory)
interface lsu_ctrl_if;
   import control_types::*;

   // core side
   logic        lsu_req;
   mem_op_e     lsu_wr;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic        stall;
   logic [31:0] ld_data;
   logic        ld_vld;
   logic        err;

   // memory side
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  lsu_req, lsu_wr, funct3, addr, st_data, mem_ack, mem_rdata,
      output stall, ld_data, ld_vld, err, mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output lsu_req, lsu_wr, funct3, addr, st_data, mem_ack, mem_rdata,
      input  stall, ld_data, ld_vld, err, mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

endinterface

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane steering for the load/store unit.
//   f3_i      : funct3 size/sign of the access
//   off_i     : byte offset addr[1:0] within the word
//   st_data_i : store source value
//   rdata_i   : read word returned by memory
//   be_o      : byte enables for the word access
//   wdata_o   : store data replicated across all lanes of its size
//   ld_val_o  : load lane shifted to bit 0 and sign/zero extended
module lsu_align
   import control_types::*;
(
   input  logic [2:0]  f3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_val_o
);

   logic [31:0]        lane;
   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;
   logic signed [31:0] sext_b;
   logic signed [31:0] sext_h;

   // Replicating store data lets memory pick any lane using only mem_be.
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = st_data_i;
      case (f3_i)
         SZ_B, SZ_BU: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{st_data_i[7:0]}};
         end
         SZ_H, SZ_HU: begin
            be_o    = 4'b0011 << {off_i[1], 1'b0};
            wdata_o = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign lane   = rdata_i >> {off_i, 3'b000};
   assign lane_b = lane[7:0];
   assign lane_h = lane[15:0];
   assign sext_b = 32'(lane_b);
   assign sext_h = 32'(lane_h);

   always_comb begin
      ld_val_o = lane;
      case (f3_i)
         SZ_B:    ld_val_o = sext_b;
         SZ_H:    ld_val_o = sext_h;
         SZ_BU:   ld_val_o = {24'h000000, lane[7:0]};
         SZ_HU:   ld_val_o = {16'h0000, lane[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : lsu_ctrl_if.slave -- core request/response and memory bus
// One access at a time: IDLE screens and captures a request, ACCESS holds
// the memory request until ack or TIMEOUT cycles, RESP reports for one cycle.
module lsu_ctrl
   import control_types::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input logic       clk,
   input logic       rst,
   lsu_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tout_q, tout_d;
   logic [31:0]      ld_data_q;

   logic [31:0]      addr_q;
   logic [31:0]      sdata_q;
   logic [2:0]       f3_q;
   mem_op_e          wr_q;

   logic             req_ok;
   logic             cap_en;
   logic             ld_en;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      ld_val;

   assign req_ok = lsu_legal(bus.lsu_wr, bus.funct3) &&
                   !lsu_misaligned(bus.funct3, bus.addr[1:0]);

   lsu_align u_align (
      .f3_i      (f3_q),
      .off_i     (addr_q[1:0]),
      .st_data_i (sdata_q),
      .rdata_i   (bus.mem_rdata),
      .be_o      (be),
      .wdata_o   (wdata),
      .ld_val_o  (ld_val)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tout_d      = tout_q;
      cap_en      = 1'b0;
      ld_en       = 1'b0;
      bus.stall   = 1'b0;
      bus.err     = 1'b0;
      bus.ld_vld  = 1'b0;
      bus.mem_req = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (bus.lsu_req) begin
               if (req_ok) begin
                  cap_en    = 1'b1;
                  bus.stall = 1'b1;
                  cnt_d     = '0;
                  tout_d    = 1'b0;
                  state_d   = LSU_ACCESS;
               end else begin
                  bus.err = 1'b1;
               end
            end
         end
         LSU_ACCESS: begin
            bus.mem_req = 1'b1;
            bus.stall   = 1'b1;
            // An ack in the last allowed cycle still completes normally.
            if (bus.mem_ack) begin
               ld_en   = (wr_q == READ);
               state_d = LSU_RESP;
            end else if (cnt_q == CNT_LAST) begin
               tout_d  = 1'b1;
               state_d = LSU_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LSU_RESP: begin
            // The stalled instruction is still presented here; it is not a new request.
            bus.err    = tout_q;
            bus.ld_vld = (wr_q == READ) && !tout_q;
            state_d    = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LSU_IDLE;
         cnt_q     <= '0;
         tout_q    <= 1'b0;
         ld_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
         if (ld_en) begin
            ld_data_q <= ld_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_en) begin
         addr_q  <= bus.addr;
         sdata_q <= bus.st_data;
         f3_q    <= bus.funct3;
         wr_q    <= bus.lsu_wr;
      end
   end

   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = wdata;
   assign bus.mem_we    = bus.mem_req && (wr_q == WRITE);
   assign bus.mem_be    = bus.mem_req ? be : 4'b0000;
   assign bus.ld_data   = ld_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- scoreboard bench for lsu_ctrl (TIMEOUT=4).
// Stimulus pushes expected memory requests and responses into queues; a
// negedge monitor pops them whenever the DUT raises mem_req, ld_vld or err.
module tb_lsu_ctrl;
   import control_types::*;

   localparam int TMO = 4;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mexp_t;

   typedef struct {
      logic        is_err;
      logic [31:0] data;
   } rexp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mexp_t mq[$];
   rexp_t rq[$];
   mexp_t cur;
   bit    in_txn = 1'b0;

   lsu_ctrl_if bus ();

   lsu_ctrl #(.TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: responses and memory requests checked against the queues.
   always @(negedge clk) begin
      rexp_t r;
      if (bus.ld_vld === 1'b1 || bus.err === 1'b1) begin
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: ld_vld=%b err=%b with none expected", bus.ld_vld, bus.err);
         end else begin
            r = rq.pop_front();
            chkb("resp_err", bus.err, r.is_err);
            chkb("resp_ld_vld", bus.ld_vld, !r.is_err);
            if (!r.is_err) chk("ld_data", bus.ld_data, r.data);
         end
      end
      if (bus.mem_req === 1'b1) begin
         if (!in_txn) begin
            if (mq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_mem_req: addr=%h with none expected", bus.mem_addr);
               cur = '{addr: bus.mem_addr, we: bus.mem_we, be: bus.mem_be, wdata: bus.mem_wdata};
            end else begin
               cur = mq.pop_front();
            end
         end
         chk("mem_addr", bus.mem_addr, cur.addr);
         chkb("mem_we", bus.mem_we, cur.we);
         chk("mem_be", 32'(bus.mem_be), 32'(cur.be));
         if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
      end
      in_txn = (bus.mem_req === 1'b1);
   end

   // One full access. ack_dly = index of the ACCESS cycle carrying ack, -1 = never.
   task automatic do_access(input mem_op_e wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input int ack_dly, input logic [31:0] rd,
                            input logic [31:0] exp_ld, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
      int n;
      bit done;
      bus.lsu_req = 1'b1;
      bus.lsu_wr  = wr;
      bus.funct3  = f3;
      bus.addr    = a;
      bus.st_data = sd;
      mq.push_back('{addr: {a[31:2], 2'b00}, we: (wr == WRITE), be: exp_be, wdata: exp_wd});
      if (ack_dly < 0) rq.push_back('{is_err: 1'b1, data: 32'h0});
      else if (wr == READ) rq.push_back('{is_err: 1'b0, data: exp_ld});
      @(negedge clk);
      chkb("accept_stall", bus.stall, 1'b1);
      chkb("accept_no_mem_req", bus.mem_req, 1'b0);
      tick();
      n = 0;
      done = 1'b0;
      while (!done && n < TMO + 4) begin
         if (n == ack_dly) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h5A5A_5A5A;
         end
         @(negedge clk);
         chkb("access_stall", bus.stall, 1'b1);
         chkb("access_mem_req", bus.mem_req, 1'b1);
         if (n == ack_dly || (ack_dly < 0 && n == TMO - 1)) done = 1'b1;
         n++;
         tick();
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL access_bound: got %0d cycles want completion", n);
      end
      bus.mem_ack = 1'b0;
      @(negedge clk);
      chkb("resp_stall", bus.stall, 1'b0);
      chkb("resp_mem_req", bus.mem_req, 1'b0);
      tick();
      bus.lsu_req = 1'b0;
      @(negedge clk);
      chkb("idle_stall", bus.stall, 1'b0);
      tick();
   endtask

   // Rejected request: err in the same cycle, no memory traffic.
   task automatic bad_req(input mem_op_e wr, input logic [2:0] f3, input logic [31:0] a);
      bus.lsu_req = 1'b1;
      bus.lsu_wr  = wr;
      bus.funct3  = f3;
      bus.addr    = a;
      rq.push_back('{is_err: 1'b1, data: 32'h0});
      @(negedge clk);
      chkb("reject_stall", bus.stall, 1'b0);
      chkb("reject_mem_req", bus.mem_req, 1'b0);
      tick();
      bus.lsu_req = 1'b0;
      @(negedge clk);
      chkb("reject_after_mem_req", bus.mem_req, 1'b0);
      tick();
   endtask

   initial begin
      rst           = 1'b1;
      bus.lsu_req   = 1'b0;
      bus.lsu_wr    = READ;
      bus.funct3    = 3'b000;
      bus.addr      = 32'h0;
      bus.st_data   = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chkb("rst_stall", bus.stall, 1'b0);
      chkb("rst_ld_vld", bus.ld_vld, 1'b0);
      chkb("rst_err", bus.err, 1'b0);
      chkb("rst_mem_req", bus.mem_req, 1'b0);
      chkb("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
      chk("rst_ld_data", bus.ld_data, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      do_access(READ,  3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h0);
      do_access(READ,  3'b000, 32'h0000_0103, 32'h0, 0, 32'h8011_2233, 32'hFFFF_FF80, 4'b1000, 32'h0);
      do_access(READ,  3'b100, 32'h0000_0103, 32'h0, 0, 32'h8011_2233, 32'h0000_0080, 4'b1000, 32'h0);
      do_access(READ,  3'b101, 32'h0000_0102, 32'h0, 0, 32'h8011_2233, 32'h0000_8011, 4'b1100, 32'h0);
      do_access(READ,  3'b001, 32'h0000_0102, 32'h0, 1, 32'h8011_2233, 32'hFFFF_8011, 4'b1100, 32'h0);

      do_access(WRITE, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 2, 32'h0, 32'h0, 4'b1100, 32'hABCD_ABCD);
      chk("ld_data_hold_store", bus.ld_data, 32'hFFFF_8011);
      do_access(WRITE, 3'b000, 32'h0000_0201, 32'h0000_00A5, 0, 32'h0, 32'h0, 4'b0010, 32'hA5A5_A5A5);
      do_access(WRITE, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 1, 32'h0, 32'h0, 4'b1111, 32'hCAFE_F00D);

      bad_req(READ,  3'b010, 32'h0000_0101);
      bad_req(READ,  3'b001, 32'h0000_0101);
      bad_req(WRITE, 3'b011, 32'h0000_0200);
      bad_req(WRITE, 3'b100, 32'h0000_0200);
      bad_req(READ,  3'b110, 32'h0000_0100);

      do_access(READ, 3'b010, 32'h0000_0300, 32'h0, -1, 32'h0, 32'h0, 4'b1111, 32'h0);
      chk("ld_data_hold_timeout", bus.ld_data, 32'hFFFF_8011);

      // Reset during the second ACCESS cycle, then a late ack.
      bus.lsu_req = 1'b1;
      bus.lsu_wr  = READ;
      bus.funct3  = 3'b010;
      bus.addr    = 32'h0000_0400;
      mq.push_back('{addr: 32'h0000_0400, we: 1'b0, be: 4'b1111, wdata: 32'h0});
      @(negedge clk);
      tick();
      @(negedge clk);
      chkb("rstmid_acc0_mem_req", bus.mem_req, 1'b1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      tick();
      rst           = 1'b0;
      bus.lsu_req   = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chkb("rstmid_mem_req", bus.mem_req, 1'b0);
      chkb("rstmid_stall", bus.stall, 1'b0);
      chk("rstmid_ld_data", bus.ld_data, 32'h0);
      tick();
      bus.mem_ack = 1'b0;
      @(negedge clk);
      chkb("rstmid_late_mem_req", bus.mem_req, 1'b0);
      tick();

      do_access(READ, 3'b010, 32'h0000_0104, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'h0);

      repeat (3) tick();
      chk("mem_queue_empty", mq.size(), 32'h0);
      chk("resp_queue_empty", rq.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
